// File: rtl/register_file_if.sv
// register_file_if: bus bundle between the accumulator/decoder side and the
// register file.
//   A       write data from the accumulator (DATA_W)
//   RegCE   write enable
//   RegNum  one-hot (multi-hot legal) register select (NUM_REGS)
//   out     combinational read data (DATA_W)
// master: drives A/RegCE/RegNum, receives out. slave: the register file.
interface register_file_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4
);
   logic [DATA_W-1:0]   A;
   logic                RegCE;
   logic [NUM_REGS-1:0] RegNum;
   logic [DATA_W-1:0]   out;

   modport master (output A, output RegCE, output RegNum, input out);
   modport slave  (input A, input RegCE, input RegNum, output out);
endinterface

// File: rtl/register_file.sv
// register_file: NUM_REGS x DATA_W general-purpose registers for the datapath.
// Ports:
//   clk     system clock, all updates on the rising edge
//   nReset  synchronous reset, active HIGH despite the name; clears every register
//   bus     register_file_if.slave (A, RegCE, RegNum in; out out)
// Write: at the edge with RegCE=1, every register whose RegNum bit is set loads A.
// Read:  out is the OR of all selected registers, purely combinational.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a register being
// written this cycle contributes A to out instead of its stored value
// (suppressed while reset is asserted).
module register_file #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4
) (
   input  logic           clk,
   input  logic           nReset,
   register_file_if.slave bus
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] rd_term;

   always_comb begin
      regs_d = regs_q;
      if (bus.RegCE) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.RegNum[i]) begin
               regs_d[i] = bus.A;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (nReset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Multi-hot selects OR together, so the decoder can read a merged value.
   always_comb begin
      rd_data = '0;
      rd_term = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_term = regs_q[i];
`ifdef REGFILE_BYPASS_EN
         if (bus.RegCE && !nReset && bus.RegNum[i]) begin
            rd_term = bus.A;
         end
`endif
         if (bus.RegNum[i]) begin
            rd_data = rd_data | rd_term;
         end
      end
   end

   assign bus.out = rd_data;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

   localparam int DW = 8;
   localparam int NR = 4;

   logic clk;
   logic nReset;

   register_file_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

   register_file #(.DATA_W(DW), .NUM_REGS(NR)) dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // reference model: plain array of register contents
   logic [DW-1:0] mem [NR];
   bit            mem_valid = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic rst, input logic ce,
                                                input logic [NR-1:0] sel, input logic [DW-1:0] a);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < NR; i++) begin
         if (sel[i]) begin
`ifdef REGFILE_BYPASS_EN
            if (ce && !rst) r = r | a;
            else            r = r | mem[i];
`else
            r = r | mem[i];
`endif
         end
      end
      return r;
   endfunction

   // One cycle: drive, check the combinational read before the edge,
   // clock, update the model, check again after the edge.
   task automatic apply(input string tag, input logic rst, input logic ce,
                        input logic [NR-1:0] sel, input logic [DW-1:0] a);
      nReset     = rst;
      bus.RegCE  = ce;
      bus.RegNum = sel;
      bus.A      = a;
      #1;
      if (mem_valid) check({tag, "_pre"}, bus.out, model_read(rst, ce, sel, a));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NR; i++) mem[i] = '0;
         mem_valid = 1;
      end else if (ce) begin
         for (int i = 0; i < NR; i++) if (sel[i]) mem[i] = a;
      end
      #1;
      check({tag, "_post"}, bus.out, model_read(rst, ce, sel, a));
   endtask

   initial begin
      nReset = 1'b0; bus.RegCE = 1'b0; bus.RegNum = '0; bus.A = '0;
      @(negedge clk);

      // reset beats a simultaneous write
      apply("reset", 1'b1, 1'b1, 4'b0001, 8'hFF);
      check("reset_out_zero", bus.out, 8'h00);
      for (int i = 0; i < NR; i++) begin
         apply("reset_rd", 1'b0, 1'b0, 4'(1 << i), 8'hFF);
         check("reset_reg_zero", bus.out, 8'h00);
      end

      // sequential one-hot writes, then read back
      for (int i = 0; i < NR; i++) begin
         apply("seq_wr", 1'b0, 1'b1, 4'(1 << i), 8'(4 + i));
         check("seq_wr_val", bus.out, 8'(4 + i));
      end
      for (int i = 0; i < NR; i++) begin
         apply("seq_rd", 1'b0, 1'b0, 4'(1 << i), 8'h00);
         check("seq_rd_val", bus.out, 8'(4 + i));
      end

      // no select
      apply("nosel", 1'b0, 1'b1, 4'b0000, 8'h55);
      check("nosel_out", bus.out, 8'h00);

      // write disabled
      for (int k = 0; k < 3; k++) apply("wdis", 1'b0, 1'b0, 4'b0010, 8'hAA);
      check("wdis_r1", bus.out, 8'h05);

      // multi-hot read OR and broadcast write
      apply("mh_w0", 1'b0, 1'b1, 4'b0001, 8'h0F);
      apply("mh_w1", 1'b0, 1'b1, 4'b0010, 8'hF0);
      apply("mh_rd", 1'b0, 1'b0, 4'b0011, 8'h00);
      check("mh_or", bus.out, 8'hFF);
      apply("mh_bc", 1'b0, 1'b1, 4'b0011, 8'h3C);
      check("mh_bc_out", bus.out, 8'h3C);
      apply("mh_r0", 1'b0, 1'b0, 4'b0001, 8'h00);
      check("mh_r0_val", bus.out, 8'h3C);

      // bypass behaviour before the edge
      apply("byp_w", 1'b0, 1'b1, 4'b0100, 8'h06);
      nReset = 1'b0; bus.RegCE = 1'b1; bus.RegNum = 4'b0100; bus.A = 8'h09;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_pre", bus.out, 8'h09);
`else
      check("byp_pre", bus.out, 8'h06);
`endif
      apply("byp", 1'b0, 1'b1, 4'b0100, 8'h09);
      check("byp_post", bus.out, 8'h09);

      // randomized traffic, including occasional mid-operation reset
      for (int n = 0; n < 400; n++) begin
         apply("rand", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)), 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
